vec_result_demux13: RTL
=======================

Name: vec_result_demux13

Overview:
- 1-to-3 result distributor: steers a 16-bit operand/result element stream to one of three destination ports (A, B, C) under a per-transfer command.
- Inverse of the 3:1 operand mux on the datapath read side; sits on the write-back side of the memory-to-memory vector unit.
- Each command names a destination and an element count. The block forwards exactly that many elements through a one-deep registered stage, with valid/ready on every interface, then pulses done.

Parameters:
- WIDTH, 16, element data width
- CNT_W, 8, element-count width; max transfer 2^CNT_W - 1 elements

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command offered
- cmd_ready  output  1  block can accept a command (high only in IDLE)
- cmd_dest  input  2  0=A, 1=B, 2=C, 3=illegal
- cmd_len  input  CNT_W  number of elements to forward
- in_data  input  WIDTH  stream element
- in_valid  input  1  element offered
- in_ready  output  1  element accepted when in_valid && in_ready
- out_a_data / out_b_data / out_c_data  output  WIDTH  destination data
- out_a_valid / out_b_valid / out_c_valid  output  1  destination element valid
- out_a_ready / out_b_ready / out_c_ready  input  1  destination accepts
- busy  output  1  high in XFER or DRAIN
- done  output  1  one-cycle pulse at transfer completion
- err  output  1  one-cycle pulse on illegal command

Behaviour:
- Reset (async on rst_n low): state=IDLE; hold_valid=0; remaining=0; dest=0; hold_data=0. All out_*_valid=0, all out_*_data=0, in_ready=0, busy=0, done=0, err=0, cmd_ready=1 (it follows IDLE).
- Reset mid-transfer: the element in the holding register is discarded and the count is lost. No done is issued.
- States:
  - IDLE: cmd_ready=1. On cmd_valid:
    - cmd_dest==3: err=1 next cycle, stay IDLE, no data consumed.
    - cmd_len==0: done=1 next cycle, stay IDLE.
    - otherwise: latch dest and remaining=cmd_len, go to XFER.
  - XFER: in_ready = (remaining!=0) && (!hold_valid || sel_ready), where sel_ready is the ready of the latched dest. On an input handshake: hold_data<=in_data, hold_valid<=1, remaining<=remaining-1. When remaining reaches 0, go to DRAIN.
  - DRAIN: in_ready=0. When hold_valid && sel_ready, clear hold_valid, pulse done, go to IDLE. If hold_valid is already 0, go to IDLE with done.
- Output steering:
  - out_X_valid = hold_valid && (dest==X). Non-selected valids stay 0.
  - All three out_*_data are driven from hold_data; the data bus is shared, only valid is steered.
- Latency: an element accepted at edge N is presented on the destination at N+1.
- Throughput: one element per cycle. Simultaneous output handshake and input handshake in the same cycle is a legal pass-through: the register reloads and hold_valid stays 1.
- Holding register: the destination may hold ready low indefinitely. hold_data and out_valid must stay stable until the handshake completes.
- Counter: remaining decrements only on an input handshake and never wraps below 0. cmd_len = 2^CNT_W-1 is legal.
- Commands are not accepted outside IDLE (cmd_ready=0). cmd_dest and cmd_len are sampled only on the accepting edge.
- done and err are mutually exclusive and each lasts exactly one cycle.

Decomposition:
- Shared package (vec_pkg):
  - DEST_A=2'd0, DEST_B=2'd1, DEST_C=2'd2, DEST_BAD=2'd3, also used by the read-side 3:1 mux select.
  - State encoding IDLE/XFER/DRAIN.
  - Default WIDTH=16.
- Natural sub-module: vec_hold_stage, a one-entry valid/ready register slice (data, valid, load/unload). The top keeps the FSM, counter and steering.

Test Plan:
- Basic routing: cmd dest=1, len=3; in 0x1111, 0x2222, 0x3333 back-to-back; out_b_ready=1 -> out_b_valid carries the three values on consecutive cycles starting 1 cycle after the first input. out_a_valid and out_c_valid stay 0. done pulses once, the cycle after the last output handshake.
- Backpressure: dest=2, len=2, out_c_ready=0 for 5 cycles -> 0xBEEF held stable on out_c_data with valid=1. in_ready=0 while the register is full. Releasing ready completes both elements in order, then done.
- Zero length: cmd dest=0, len=0 -> done pulses next cycle, in_ready never asserts, no out valid.
- Illegal dest: cmd dest=3, len=5 -> err pulses next cycle. in_ready stays 0, state returns to IDLE, a following legal command is accepted.
- Async reset mid-transfer: dest=0, len=4, reset after 2 elements with out_a_ready=0 -> all valids drop immediately, no done. A new command dest=2, len=1 afterwards routes 0x00FF only to C.
- Max length: len=255 with continuous valid/ready -> exactly 255 elements forwarded at full rate, done once. The 256th offered element is not accepted.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared definitions for the memory-to-memory vector unit datapath.
// Destination codes are common to the write-side demux and the read-side operand mux.
package vec_pkg;

    localparam int unsigned VEC_WIDTH = 16;
    localparam int unsigned VEC_CNT_W = 8;

    localparam logic [1:0] DEST_A   = 2'd0;
    localparam logic [1:0] DEST_B   = 2'd1;
    localparam logic [1:0] DEST_C   = 2'd2;
    localparam logic [1:0] DEST_BAD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/vec_hold_stage.sv
// One-entry valid/ready register slice; a load takes priority over an unload,
// which makes a same-cycle unload+load a pass-through reload.
module vec_hold_stage #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             unload,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/vec_result_demux13.sv
// 1-to-3 result distributor: forwards cmd_len elements through a one-deep
// holding stage to destination A, B or C, then pulses done.
module vec_result_demux13
    import vec_pkg::*;
#(
    parameter int unsigned WIDTH = VEC_WIDTH,
    parameter int unsigned CNT_W = VEC_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_dest,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_a_data,
    output logic             out_a_valid,
    input  logic             out_a_ready,
    output logic [WIDTH-1:0] out_b_data,
    output logic             out_b_valid,
    input  logic             out_b_ready,
    output logic [WIDTH-1:0] out_c_data,
    output logic             out_c_valid,
    input  logic             out_c_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_e           state;
    logic [1:0]       dest;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] hold_data;
    logic             hold_valid;
    logic             sel_ready;
    logic             in_hs;
    logic             out_hs;

    // Ready of the currently latched destination
    always_comb begin
        sel_ready = 1'b0;
        unique case (dest)
            DEST_A:  sel_ready = out_a_ready;
            DEST_B:  sel_ready = out_b_ready;
            DEST_C:  sel_ready = out_c_ready;
            default: sel_ready = 1'b0;
        endcase
    end

    assign in_ready = (state == ST_XFER) && (remaining != '0) && (!hold_valid || sel_ready);
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = hold_valid && sel_ready;

    vec_hold_stage #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (in_hs),
        .unload    (out_hs),
        .load_data (in_data),
        .data      (hold_data),
        .valid     (hold_valid)
    );

    // Data bus is shared; only valid is steered
    assign out_a_data  = hold_data;
    assign out_b_data  = hold_data;
    assign out_c_data  = hold_data;
    assign out_a_valid = hold_valid && (dest == DEST_A);
    assign out_b_valid = hold_valid && (dest == DEST_B);
    assign out_c_valid = hold_valid && (dest == DEST_C);

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // Control FSM with element counter and one-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            dest      <= DEST_A;
            remaining <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_dest == DEST_BAD) begin
                            err <= 1'b1;
                        end else if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            dest      <= cmd_dest;
                            remaining <= cmd_len;
                            state     <= ST_XFER;
                        end
                    end
                end
                ST_XFER: begin
                    if (in_hs) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!hold_valid || sel_ready) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
